seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised sequential multiplier for the MIPS_CPU datapath. It is the generalised successor of the 4-bit shift-add unit: operand width is set by a parameter, a per-operation mode selects unsigned shift-add or signed radix-2 Booth, and the result sits in a held output register. The block sits beside the ALU and is driven by the CPU control unit through an St/Done/Idle handshake. It returns a full 2×WIDTH-bit product after a fixed latency.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2×WIDTH bits.
- Clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; low forces reset state immediately.
- St  input  1  start request; sampled only in IDLE.
- Signed_mode  input  1  sampled with St: 0 = unsigned, 1 = two's-complement signed.
- Abort  input  1  synchronous cancel of an operation in progress.
- Multiplicando  input  WIDTH  multiplicand; sampled with St.
- Multiplicador  input  WIDTH  multiplier; sampled with St.
- Produto  output  2×WIDTH  registered result; changes only on entry to DONE.
- Idle  output  1  high while in IDLE (decoded from state).
- Done  output  1  high for exactly one cycle, in DONE.

## Operation
- States: IDLE, CALC, DONE. The state register, the iteration counter (ceil(log2(WIDTH+1)) bits), the accumulator and the result register are separate registers.
- IDLE:
  - On St=1 at an edge: latch both operands and Signed_mode, clear the accumulator, load the counter with WIDTH, go to CALC.
  - On St=0: stay in IDLE.
- Unsigned mode, each CALC cycle:
  - If the accumulator LSB is 1, add the multiplicand to the upper half, producing a WIDTH+1-bit sum that keeps the carry.
  - Then logical right-shift the {carry, upper, lower} accumulator by 1.
- Signed mode, each CALC cycle:
  - Booth pair {acc[0], q-1}: 01 adds the multiplicand, 10 subtracts it, 00/11 does nothing.
  - The upper part is sign-extended to WIDTH+1 bits.
  - Then arithmetic right-shift the accumulator and q-1.
- Counter decrements each CALC cycle. When it reaches 1, the next edge goes to DONE and loads the final 2×WIDTH-bit accumulator into Produto.
- DONE: Done=1 for one cycle, then unconditionally back to IDLE. An St high during DONE is ignored. It is first accepted in the following IDLE cycle.
- Width rules:
  - Unsigned results are exact, up to (2^WIDTH−1)^2.
  - Signed results are exact, including −2^(WIDTH−1) × −2^(WIDTH−1) = 2^(2WIDTH−2). No overflow is possible.
- Abort=1 in CALC: next state IDLE, Produto unchanged, no Done pulse. Abort is ignored in IDLE and DONE.
- St, operand and mode changes during CALC/DONE have no effect on the operation in progress.

## Timing
- Reset (reset low, asynchronous):
  - State IDLE, Produto=0, Done=0, Idle=1.
  - Accumulator and counter cleared.
  - Takes effect mid-operation with no result written.
- Latency:
  - St sampled at edge E0.
  - CALC occupies cycles E0..E0+WIDTH.
  - Edge E0+WIDTH enters DONE and updates Produto.
  - Done high for the cycle between E0+WIDTH and E0+WIDTH+1.
  - Idle returns at edge E0+WIDTH+1.
- Throughput: one product every WIDTH+2 cycles, with St held high continuously.
- Produto holds the previous result throughout CALC and Abort, and stays stable until the next completed operation.
- Idle and Done are never high together.

## Test plan
- WIDTH=8, unsigned.
  - Stimulus: 255×255, St pulse.
  - Response: Produto=0xFE01.
  - Done rises exactly 8 cycles after the St edge.
  - Idle low for 9 cycles.
- WIDTH=8, signed.
  - Stimulus: −3×5 (0xFD, 0x05), then −128×−128 (0x80, 0x80).
  - Response: Produto=0xFFF1, then 0x4000.
  - Same stimulus in unsigned mode: 0xFD×0x05 gives 0x04F1.
- Back-to-back with St held high: a 6×7 then a 9×9 operand change applied after the first St edge.
  - Response: first result 42 (inputs re-sampled only at the next IDLE).
  - Exactly WIDTH+2 cycles between Done pulses.
- Ignored requests:
  - Stimulus: pulse St during CALC and during DONE.
  - Response: no restart.
  - Produto reflects only the original operands.
- Abort and reset:
  - Stimulus: Abort at CALC cycle 3.
  - Response: Idle the next cycle, Produto keeps its prior value, no Done.
  - Stimulus: reset low at CALC cycle 5.
  - Response: immediate Idle=1, Produto=0, Done=0. A following 12×12 gives 144.
- WIDTH=4 and WIDTH=16 instances.
  - Stimulus: exhaustive (WIDTH=4) or random 10k-vector (WIDTH=16) comparison against a reference model, both modes.
  - Response: all match; latency is WIDTH cycles to Done.

Source files
------------

// File: rtl/seq_multiplier_if.sv
// Handshake and operand/result bundle between the CPU control unit and seq_multiplier.
// The master side drives requests and the slave side returns the product and status.
interface seq_multiplier_if #(parameter int WIDTH = 8);
  logic                   St;
  logic                   Signed_mode;
  logic                   Abort;
  logic [WIDTH-1:0]       Multiplicando;
  logic [WIDTH-1:0]       Multiplicador;
  logic [2*WIDTH-1:0]     Produto;
  logic                   Idle;
  logic                   Done;

  modport master (
    output St, Signed_mode, Abort, Multiplicando, Multiplicador,
    input  Produto, Idle, Done
  );

  modport slave (
    input  St, Signed_mode, Abort, Multiplicando, Multiplicador,
    output Produto, Idle, Done
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier: unsigned shift-add or signed radix-2 Booth, one bit per cycle.
// Latency WIDTH cycles from the St edge to Done; St is only accepted in IDLE, so back-to-back ops take WIDTH+2 cycles.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input logic           Clk,
  input logic           reset,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     acc_hi_q;
  logic [WIDTH-1:0]     acc_lo_q;
  logic                 qm1_q;
  logic                 sgn_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 done_q;
  logic                 idle_q;

  logic [WIDTH:0]       mcand_ext;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_d;
  logic                 qm1_d;

  // One iteration: the WIDTH+1-bit sum keeps the unsigned carry or the signed
  // sign bit, so the shift below never loses information.
  always_comb begin
    mcand_ext = sgn_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
    addend    = '0;
    if (sgn_q) begin
      case ({acc_lo_q[0], qm1_q})
        2'b01:   addend = mcand_ext;
        2'b10:   addend = '0 - mcand_ext;
        default: addend = '0;
      endcase
    end else if (acc_lo_q[0]) begin
      addend = mcand_ext;
    end
    sum      = (sgn_q ? {acc_hi_q[WIDTH-1], acc_hi_q} : {1'b0, acc_hi_q}) + addend;
    acc_hi_d = sum[WIDTH:1];
    acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
    qm1_d    = acc_lo_q[0];
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      qm1_q    <= 1'b0;
      sgn_q    <= 1'b0;
      prod_q   <= '0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.St) begin
            mcand_q  <= bus.Multiplicando;
            acc_hi_q <= '0;
            acc_lo_q <= bus.Multiplicador;
            qm1_q    <= 1'b0;
            sgn_q    <= bus.Signed_mode;
            cnt_q    <= CW'(WIDTH);
            state_q  <= CALC;
            idle_q   <= 1'b0;
          end
        end
        CALC: begin
          if (bus.Abort) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              prod_q  <= {acc_hi_d, acc_lo_d};
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Produto = prod_q;
  assign bus.Idle    = idle_q;
  assign bus.Done    = done_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: WIDTH=8 directed/table/random cases and an exhaustive WIDTH=4 sweep.
module tb_seq_multiplier;
  logic Clk;
  logic reset;

  seq_multiplier_if #(.WIDTH(8)) m8 ();
  seq_multiplier_if #(.WIDTH(4)) m4 ();

  seq_multiplier #(.WIDTH(8)) dut8 (.Clk(Clk), .reset(reset), .bus(m8));
  seq_multiplier #(.WIDTH(4)) dut4 (.Clk(Clk), .reset(reset), .bus(m4));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] q8[$];
  logic [7:0]  q4[$];
  logic [15:0] last_prod;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'h00, a};
    eb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return 16'(ea * eb);
  endfunction

  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [7:0] ea, eb;
    ea = s ? {{4{a[3]}}, a} : {4'h0, a};
    eb = s ? {{4{b[3]}}, b} : {4'h0, b};
    return 8'(ea * eb);
  endfunction

  // Scoreboards: every Done pops the oldest expected product
  always @(negedge Clk) begin
    if (reset && m8.Done) begin
      check("idle_done_excl8", {31'd0, m8.Idle}, 32'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: Done with no request pending, Produto=0x%0h", m8.Produto);
      end else begin
        check("prod8", {16'd0, m8.Produto}, {16'd0, q8.pop_front()});
      end
    end
    if (reset && m4.Done) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done4: Done with no request pending, Produto=0x%0h", m4.Produto);
      end else begin
        check("prod4", {24'd0, m4.Produto}, {24'd0, q4.pop_front()});
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
    int cyc;
    int idle_low;
    @(negedge Clk);
    m8.St = 1'b1; m8.Multiplicando = a; m8.Multiplicador = b; m8.Signed_mode = s;
    q8.push_back(exp);
    @(negedge Clk);
    m8.St = 1'b0;
    cyc = 1;
    idle_low = m8.Idle ? 0 : 1;
    while (!m8.Done && cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (!m8.Idle) idle_low++;
    end
    check("latency8", cyc, 9);
    check("idle_low8", idle_low, 9);
    @(negedge Clk);
    check("idle_back8", {31'd0, m8.Idle}, 32'd1);
    last_prod = exp;
  endtask

  vec_t tbl[8];

  initial begin
    int n;
    int t1;
    int t2;
    int cyc;

    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[3] = '{8'hFD, 8'h05, 1'b0, 16'h04F1};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 16'h0000};
    tbl[5] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tbl[6] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[7] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};

    reset = 1'b0;
    m8.St = 1'b0; m8.Signed_mode = 1'b0; m8.Abort = 1'b0;
    m8.Multiplicando = '0; m8.Multiplicador = '0;
    m4.St = 1'b0; m4.Signed_mode = 1'b0; m4.Abort = 1'b0;
    m4.Multiplicando = '0; m4.Multiplicador = '0;
    repeat (2) @(negedge Clk);
    check("rst_idle", {31'd0, m8.Idle}, 32'd1);
    check("rst_done", {31'd0, m8.Done}, 32'd0);
    check("rst_prod", {16'd0, m8.Produto}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) op8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic       s;
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      op8(a, b, s, model8(a, b, s));
    end

    // St held high: operands changed after the first edge only affect the second op
    @(negedge Clk);
    m8.St = 1'b1; m8.Signed_mode = 1'b0; m8.Multiplicando = 8'd6; m8.Multiplicador = 8'd7;
    q8.push_back(16'd42);
    @(negedge Clk);
    m8.Multiplicando = 8'd9; m8.Multiplicador = 8'd9;
    q8.push_back(16'd81);
    n = 1;
    while (!m8.Done && n < 60) begin @(negedge Clk); n++; end
    t1 = n;
    @(negedge Clk); n++;
    while (!m8.Done && n < 60) begin @(negedge Clk); n++; end
    t2 = n;
    m8.St = 1'b0;
    check("b2b_first_latency", t1, 9);
    check("b2b_spacing", t2 - t1, 10);
    last_prod = 16'd81;
    @(negedge Clk);

    // St pulses during CALC and DONE are ignored
    @(negedge Clk);
    m8.St = 1'b1; m8.Multiplicando = 8'd13; m8.Multiplicador = 8'd11; m8.Signed_mode = 1'b0;
    q8.push_back(16'd143);
    @(negedge Clk);
    m8.St = 1'b0;
    n = 1;
    while (!m8.Done && n < 40) begin
      @(negedge Clk);
      n++;
      if (n == 3) begin
        m8.St = 1'b1; m8.Multiplicando = 8'd2; m8.Multiplicador = 8'd2;
      end else begin
        m8.St = 1'b0;
      end
    end
    check("ignore_latency", n, 9);
    m8.St = 1'b1;
    @(negedge Clk);
    m8.St = 1'b0;
    repeat (3) @(negedge Clk);
    check("ignore_no_restart", {31'd0, m8.Idle}, 32'd1);
    last_prod = 16'd143;

    // Abort at CALC cycle 3
    @(negedge Clk);
    m8.St = 1'b1; m8.Multiplicando = 8'h55; m8.Multiplicador = 8'h33;
    @(negedge Clk);
    m8.St = 1'b0;
    repeat (2) @(negedge Clk);
    m8.Abort = 1'b1;
    @(negedge Clk);
    m8.Abort = 1'b0;
    check("abort_idle", {31'd0, m8.Idle}, 32'd1);
    check("abort_prod", {16'd0, m8.Produto}, {16'd0, last_prod});
    repeat (12) @(negedge Clk);
    check("abort_prod_hold", {16'd0, m8.Produto}, {16'd0, last_prod});

    // Reset mid-operation at CALC cycle 5
    @(negedge Clk);
    m8.St = 1'b1; m8.Multiplicando = 8'h77; m8.Multiplicador = 8'h66;
    @(negedge Clk);
    m8.St = 1'b0;
    repeat (4) @(negedge Clk);
    reset = 1'b0;
    #1;
    check("rst_mid_idle", {31'd0, m8.Idle}, 32'd1);
    check("rst_mid_prod", {16'd0, m8.Produto}, 32'd0);
    check("rst_mid_done", {31'd0, m8.Done}, 32'd0);
    @(negedge Clk);
    reset = 1'b1;
    op8(8'd12, 8'd12, 1'b0, 16'd144);

    // Exhaustive WIDTH=4, both modes
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          @(negedge Clk);
          m4.St = 1'b1; m4.Signed_mode = 1'(s);
          m4.Multiplicando = 4'(a); m4.Multiplicador = 4'(b);
          q4.push_back(model4(4'(a), 4'(b), 1'(s)));
          @(negedge Clk);
          m4.St = 1'b0;
          cyc = 1;
          while (!m4.Done && cyc < 20) begin @(negedge Clk); cyc++; end
          check("latency4", cyc, 5);
          @(negedge Clk);
        end
      end
    end

    repeat (3) @(negedge Clk);
    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
